// File: rtl/al_div_pkg.sv
// Shared definitions for the iterative restoring divider.
//   div_state_e : control states (IDLE, RUN, FIN)
//   CNT_W       : iteration counter width for the default 8-bit build
//   ALL_ONES    : all-ones quotient returned on divide by zero, at the widest legal size
//   cnt_width() : iteration counter width for any legal operand width
package al_div_pkg;

  localparam int unsigned WIDTH_MAX = 32;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

  localparam logic [WIDTH_MAX-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // WIDTH-1 always fits in $clog2(WIDTH) bits for WIDTH >= 2.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/al_div_step.sv
// One restoring-division stage, modelled as a single carry-chain subtract.
// Ports:
//   rem_acc  : partial remainder before this step
//   q_msb    : dividend bit being shifted into the remainder
//   dvs      : divisor
//   rem_next : remainder if the trial subtract is kept (trial difference)
//   q_bit    : quotient bit produced by this step (1 when no borrow)
//   borrow   : borrow out of the WIDTH+1-bit subtract
module al_div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_acc,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit,
  output logic             borrow
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The top remainder bit is kept in the shift so it is not lost before the compare.
  always_comb begin
    shifted  = {rem_acc, q_msb};
    diff     = shifted - {1'b0, dvs};
    borrow   = diff[WIDTH];
    q_bit    = ~diff[WIDTH];
    rem_next = diff[WIDTH-1:0];
  end

endmodule

// File: rtl/al_alu_div_seq.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro AL_ALU_DIV_SIGNED_EN adds the is_signed port for truncating
// two's-complement division; without it all division is unsigned.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, honoured only while idle and not in the done cycle
//   is_signed   : (AL_ALU_DIV_SIGNED_EN only) operands are two's complement
//   dividend    : numerator, captured on accepted start
//   divisor     : denominator, captured on accepted start
//   busy        : operation in progress
//   done        : one-cycle pulse when results update
//   quotient    : result quotient
//   remainder   : result remainder
//   div_zero    : last operation had a zero divisor
module al_alu_div_seq
  import al_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef AL_ALU_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  div_state_e       state, state_nxt;
  logic             busy_nxt, done_nxt, div_zero_nxt;
  logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
  logic [WIDTH-1:0] rem_acc, rem_nxt;
  logic [WIDTH-1:0] q_acc, q_nxt;
  logic [WIDTH-1:0] dvs, dvs_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic             step_borrow;

`ifdef AL_ALU_DIV_SIGNED_EN
  logic neg_q, neg_q_nxt;
  logic neg_r, neg_r_nxt;
  logic a_neg, b_neg;

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction
`endif

  al_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_acc  (rem_acc),
    .q_msb    (q_acc[WIDTH-1]),
    .dvs      (dvs),
    .rem_next (step_rem),
    .q_bit    (step_qbit),
    .borrow   (step_borrow)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      rem_acc   <= '0;
      q_acc     <= '0;
      dvs       <= '0;
      cnt       <= '0;
`ifdef AL_ALU_DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      quotient  <= quotient_nxt;
      remainder <= remainder_nxt;
      div_zero  <= div_zero_nxt;
      rem_acc   <= rem_nxt;
      q_acc     <= q_nxt;
      dvs       <= dvs_nxt;
      cnt       <= cnt_nxt;
`ifdef AL_ALU_DIV_SIGNED_EN
      neg_q     <= neg_q_nxt;
      neg_r     <= neg_r_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    div_zero_nxt  = div_zero;
    rem_nxt       = rem_acc;
    q_nxt         = q_acc;
    dvs_nxt       = dvs;
    cnt_nxt       = cnt;
`ifdef AL_ALU_DIV_SIGNED_EN
    neg_q_nxt     = neg_q;
    neg_r_nxt     = neg_r;
    a_neg         = is_signed & dividend[WIDTH-1];
    b_neg         = is_signed & divisor[WIDTH-1];
`endif

    case (state)
      IDLE: begin
        // A start seen in the done cycle is dropped; the next cycle may start.
        if (start && !done) begin
          rem_nxt   = '0;
          cnt_nxt   = CW'(WIDTH - 1);
          busy_nxt  = 1'b1;
          state_nxt = (divisor == '0) ? FIN : RUN;
`ifdef AL_ALU_DIV_SIGNED_EN
          q_nxt     = neg_if(a_neg, dividend);
          dvs_nxt   = neg_if(b_neg, divisor);
          neg_q_nxt = a_neg ^ b_neg;
          neg_r_nxt = a_neg;
`else
          q_nxt     = dividend;
          dvs_nxt   = divisor;
`endif
        end
      end

      RUN: begin
        // Restore on borrow: keep the shifted remainder instead of the difference.
        rem_nxt = step_borrow ? {rem_acc[WIDTH-2:0], q_acc[WIDTH-1]} : step_rem;
        q_nxt   = {q_acc[WIDTH-2:0], step_qbit};
        cnt_nxt = cnt - CW'(1);
        if (cnt == '0) begin
          state_nxt = FIN;
        end
      end

      FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
        // On divide by zero q_acc still holds the (magnitude of the) dividend.
        if (dvs == '0) begin
          quotient_nxt = WIDTH'(ALL_ONES);
          div_zero_nxt = 1'b1;
`ifdef AL_ALU_DIV_SIGNED_EN
          remainder_nxt = neg_if(neg_r, q_acc);
`else
          remainder_nxt = q_acc;
`endif
        end else begin
          div_zero_nxt = 1'b0;
`ifdef AL_ALU_DIV_SIGNED_EN
          quotient_nxt  = neg_if(neg_q, q_acc);
          remainder_nxt = neg_if(neg_r, rem_acc);
`else
          quotient_nxt  = q_acc;
          remainder_nxt = rem_acc;
`endif
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_al_alu_div_seq.sv
// Self-checking bench for al_alu_div_seq: arithmetic/latency model plus directed vectors.
module tb_al_alu_div_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  al_alu_div_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef AL_ALU_DIV_SIGNED_EN
    .is_signed (is_signed),
`endif
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  // Reference arithmetic straight from the division rules
  task automatic model_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sg,
                           output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                           output logic dz);
    int sa, sb;
    dz = 1'b0;
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (sg) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -(1 << (WIDTH - 1)) && sb == -1) begin
        q = a;
        r = '0;
      end else begin
        q = WIDTH'(sa / sb);
        r = WIDTH'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Transaction-level model: remaining cycles until done plus the expected result
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_q, m_r;
  logic             m_dz;
  logic             exp_busy = 1'b0, exp_done = 1'b0, exp_dz = 1'b0;
  logic [WIDTH-1:0] exp_q = '0, exp_r = '0;

  always @(posedge clk) begin
    logic was_done;
    logic sg;
    if (!rst_n) begin
      m_cnt    = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_q    = '0;
      exp_r    = '0;
      exp_dz   = 1'b0;
    end else begin
      was_done = exp_done;
      exp_done = 1'b0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          exp_done = 1'b1;
          exp_busy = 1'b0;
          exp_q    = m_q;
          exp_r    = m_r;
          exp_dz   = m_dz;
        end
      end else if (start && !was_done) begin
`ifdef AL_ALU_DIV_SIGNED_EN
        sg = is_signed;
`else
        sg = 1'b0;
`endif
        model_div(dividend, divisor, sg, m_q, m_r, m_dz);
        m_cnt    = (divisor == '0) ? 1 : WIDTH + 1;
        exp_busy = 1'b1;
      end
    end
  end

  // Every-cycle compare against the model (all outputs are architecturally held)
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_div_zero", 32'(div_zero), 32'd0);
    end else begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("quotient", 32'(quotient), 32'(exp_q));
      chk("remainder", 32'(remainder), 32'(exp_r));
      chk("div_zero", 32'(div_zero), 32'(exp_dz));
    end
  end

  int t0;

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sg);
    @(negedge clk);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = sg;
    @(negedge clk);
    t0        = cyc;
    start     = 1'b0;
    dividend  = ~a;
    divisor   = ~b;
    is_signed = ~sg;
  endtask

  task automatic wait_done(input string name, input int lat,
                           input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic dz);
    while (!done && (cyc - t0) < 40) @(negedge clk);
    chk({name, "_latency"}, 32'(cyc - t0), 32'(lat));
    chk({name, "_q"}, 32'(quotient), 32'(q));
    chk({name, "_r"}, 32'(remainder), 32'(r));
    chk({name, "_dz"}, 32'(div_zero), 32'(dz));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7
    start_op(8'd100, 8'd7, 1'b0);
    wait_done("d100_7", 9, 8'd14, 8'd2, 1'b0);
    @(negedge clk);
    chk("d100_7_done_width", 32'(done), 32'd0);

    // 255 / 1 then 5 / 200 one cycle after done
    start_op(8'd255, 8'd1, 1'b0);
    wait_done("d255_1", 9, 8'd255, 8'd0, 1'b0);
    start_op(8'd5, 8'd200, 1'b0);
    wait_done("d5_200", 9, 8'd0, 8'd5, 1'b0);

    // start raised during the done cycle is dropped
    start    = 1'b1;
    dividend = 8'd1;
    divisor  = 8'd1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", 32'(busy), 32'd0);

    // Divide by zero
    start_op(8'd37, 8'd0, 1'b0);
    wait_done("d37_0", 1, 8'hFF, 8'd37, 1'b1);

    // Start while busy ignored
    start_op(8'd50, 8'd3, 1'b0);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done("d50_3", 9, 8'd16, 8'd2, 1'b0);

    // Asynchronous reset mid-operation
    start_op(8'd200, 8'd13, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(quotient), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", 32'(done), 32'd0);
    start_op(8'd200, 8'd13, 1'b0);
    wait_done("d200_13", 9, 8'd15, 8'd5, 1'b0);

`ifdef AL_ALU_DIV_SIGNED_EN
    start_op(8'hF9, 8'd2, 1'b1);
    wait_done("s_m7_2", 9, 8'hFD, 8'hFF, 1'b0);
    start_op(8'h80, 8'hFF, 1'b1);
    wait_done("s_m128_m1", 9, 8'h80, 8'h00, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
